// File: rtl/irrigation_pkg.sv
// Shared types and widths for the irrigation sequencer.
package irrigation_pkg;

  localparam int unsigned TIMER_W = 7;
  localparam int unsigned CYCLE_W = 2;
  localparam int unsigned BCD_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WATER   = 2'd1,
    ST_SOAK    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

endpackage

// File: rtl/irrigation_sequencer_sync_edge.sv
// 2-FF synchronizer; EDGE_MODE=1 emits a one-clock rising-edge pulse,
// EDGE_MODE=0 emits the synchronized level.
module sync_edge #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  if (EDGE_MODE) begin : g_edge
    logic prev_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= sync_q[1];
      end
    end

    // Pulse is an AND of two flops, so it is glitch-free and lasts one clock.
    assign q_o = sync_q[1] & ~prev_q;
  end else begin : g_level
    assign q_o = sync_q[1];
  end

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation run sequencer: water, soak, optional re-water, lockout.
// Optional rain inhibit input enabled by IRRIGATION_RAIN_INHIBIT_EN.
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int unsigned WATER_TIME   = 10,
  parameter int unsigned SOAK_TIME    = 5,
  parameter int unsigned LOCKOUT_TIME = 20,
  parameter int unsigned MAX_CYCLES   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       dry,
  input  logic       tank_ok,
  input  logic       manual,
`ifdef IRRIGATION_RAIN_INHIBIT_EN
  input  logic       rain,
`endif
  output logic       valve,
  output logic       pump,
  output logic [1:0] state_code,
  output logic       fault,
  output logic [1:0] cycle_count,
  output logic [3:0] rem_tens,
  output logic [3:0] rem_units
);

  logic tick;
  logic start_req;
  logic dry_s;
  logic tank_ok_s;
  logic rain_s;

  sync_edge #(.EDGE_MODE(1'b1)) u_tick (
    .clock(clock), .reset(reset), .d_i(tick_in), .q_o(tick)
  );
  sync_edge #(.EDGE_MODE(1'b1)) u_manual (
    .clock(clock), .reset(reset), .d_i(manual), .q_o(start_req)
  );
  sync_edge #(.EDGE_MODE(1'b0)) u_dry (
    .clock(clock), .reset(reset), .d_i(dry), .q_o(dry_s)
  );
  sync_edge #(.EDGE_MODE(1'b0)) u_tank (
    .clock(clock), .reset(reset), .d_i(tank_ok), .q_o(tank_ok_s)
  );

`ifdef IRRIGATION_RAIN_INHIBIT_EN
  sync_edge #(.EDGE_MODE(1'b0)) u_rain (
    .clock(clock), .reset(reset), .d_i(rain), .q_o(rain_s)
  );
`else
  assign rain_s = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [CYCLE_W-1:0]   cyc_q, cyc_d;
  logic                 fault_q, fault_d;
  logic                 valve_q;
  logic [BCD_W-1:0]     rem_tens_q, rem_tens_d;
  logic [BCD_W-1:0]     rem_units_q, rem_units_d;
  logic                 expire;
  logic                 tick_dec;
  logic [TIMER_W-1:0]   shown;

  assign expire   = tick && (timer_q == TIMER_W'(1));
  assign tick_dec = tick && (timer_q > TIMER_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cyc_q       <= '0;
      fault_q     <= 1'b0;
      valve_q     <= 1'b0;
      rem_tens_q  <= '0;
      rem_units_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cyc_q       <= cyc_d;
      fault_q     <= fault_d;
      valve_q     <= (state_d == ST_WATER);
      rem_tens_q  <= rem_tens_d;
      rem_units_q <= rem_units_d;
    end
  end

  // Next-state and timer; expiry branches overwrite the plain decrement.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cyc_d   = cyc_q;
    fault_d = fault_q;

    if (tick_dec) begin
      timer_d = timer_q - TIMER_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (tank_ok_s && (dry_s || start_req) && !rain_s) begin
          state_d = ST_WATER;
          timer_d = TIMER_W'(WATER_TIME);
          cyc_d   = CYCLE_W'(1);
        end
      end
      ST_WATER: begin
        if (!tank_ok_s) begin
          state_d = ST_LOCKOUT;
          timer_d = TIMER_W'(LOCKOUT_TIME);
          fault_d = 1'b1;
        end else if (expire) begin
          state_d = ST_SOAK;
          timer_d = TIMER_W'(SOAK_TIME);
        end
      end
      ST_SOAK: begin
        if (expire) begin
          if (dry_s && tank_ok_s && !rain_s && (cyc_q < CYCLE_W'(MAX_CYCLES))) begin
            state_d = ST_WATER;
            timer_d = TIMER_W'(WATER_TIME);
            cyc_d   = cyc_q + CYCLE_W'(1);
          end else begin
            state_d = ST_LOCKOUT;
            timer_d = TIMER_W'(LOCKOUT_TIME);
          end
        end
      end
      ST_LOCKOUT: begin
        // A faulted lockout parks at 1 until the tank refills.
        if (expire && (!fault_q || tank_ok_s)) begin
          state_d = ST_IDLE;
          timer_d = '0;
          cyc_d   = '0;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    shown       = (state_d == ST_IDLE) ? '0 : timer_d;
    rem_tens_d  = BCD_W'(shown / TIMER_W'(10));
    rem_units_d = BCD_W'(shown % TIMER_W'(10));
  end

  assign valve       = valve_q;
  assign pump        = valve_q;
  assign state_code  = state_q;
  assign fault       = fault_q;
  assign cycle_count = cyc_q;
  assign rem_tens    = rem_tens_q;
  assign rem_units   = rem_units_q;

endmodule
